arbitro_cursor: RTL and testbench
=================================

ARBITRO_CURSOR -- requirements
Module: arbitro_cursor

Interface
REQ-001 SHALL have parameter PAUSA_CICLOS, default 4, meaning cycles spent in PAUSA after each move pulse (range 1..255).
REQ-002 SHALL have parameter LIMITE_TURNO, default 1000, meaning idle cycles before a turn expires (range 2..65535).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port j1_dir  input  4  player 1 direction levels: bit3 arriba, bit2 abajo, bit1 derecha, bit0 izquierda.
REQ-006 SHALL have port j1_ok  input  1  player 1 confirm level.
REQ-007 SHALL have port j2_dir  input  4  player 2 direction levels, same bit order as j1_dir.
REQ-008 SHALL have port j2_ok  input  1  player 2 confirm level.
REQ-009 SHALL have ports arriba, abajo, derecha, izquierda  output  1 each  single-cycle move pulses to the cursor datapath.
REQ-010 SHALL have port colocar  output  1  single-cycle place pulse.
REQ-011 SHALL have port timeout  output  1  single-cycle turn-expired pulse.
REQ-012 SHALL have port turno  output  1  active player: 0 = player 1, 1 = player 2.
REQ-013 SHALL have port estado  output  2  FSM state: 0 ESPERA, 1 MOVER, 2 PAUSA, 3 CAMBIO.

Function
REQ-014 SHALL register all ten player inputs every cycle into prev registers; a rising edge is cur & ~prev.
REQ-015 SHALL act only on the active player's edges; the inactive player's inputs are ignored in every state.
REQ-016 In ESPERA, an edge on the active player's ok input SHALL go to CAMBIO; ok takes priority over simultaneous direction edges.
REQ-017 In ESPERA, a direction edge with no ok edge SHALL go to MOVER and latch one direction, priority arriba > abajo > derecha > izquierda.
REQ-018 MOVER SHALL last exactly one cycle, assert only the latched direction output, then go to PAUSA.
REQ-019 Move pulse latency: the output is high in the cycle after the clock edge at which the rise is first sampled.
REQ-020 PAUSA SHALL last exactly PAUSA_CICLOS cycles, then go to ESPERA; edges arriving during PAUSA SHALL be discarded.
REQ-021 CAMBIO SHALL last one cycle, assert colocar (confirm entry) or timeout (expiry entry), never both, and toggle turno on exit to ESPERA.
REQ-022 A turn timer SHALL count cycles in ESPERA and PAUSA, clear on every MOVER and CAMBIO, and on reaching LIMITE_TURNO-1 force CAMBIO with timeout.
REQ-023 If timer expiry and an ok edge occur in the same cycle, ok SHALL win and colocar is asserted.
REQ-024 Buttons the new player already holds at turn change SHALL NOT generate edges, because prev tracks both players continuously.
REQ-025 At most one of arriba, abajo, derecha, izquierda, colocar, timeout SHALL be high in any cycle.

Reset
REQ-026 Asserting reset SHALL immediately force estado = ESPERA, turno = 0, all pulse outputs 0, and timers 0; prev registers are forced to all ones.
REQ-027 Reset mid-MOVER or mid-PAUSA SHALL abort without emitting any pulse; held buttons SHALL NOT cause a pulse after release.

Configuration
REQ-028 Macro AUTO_REPETIR_EN defined: at PAUSA exit, if the latched direction is still held by the active player, the block SHALL re-enter MOVER directly; repeat period = PAUSA_CICLOS+1 cycles.
REQ-029 Macro AUTO_REPETIR_EN undefined: PAUSA always exits to ESPERA and only fresh rising edges produce moves.

Verification
REQ-030 Reset, then j1_dir=1000 held for 10 cycles -> exactly one arriba pulse, one cycle after sampling; estado sequence 1,2,2,2,2,0.
REQ-031 turno=0, j1_dir 0000->0110 in one cycle -> single abajo pulse, derecha never asserted.
REQ-032 j2_dir rises while turno=0 -> no outputs; j1_ok rise -> colocar high one cycle, turno=1 after CAMBIO.
REQ-033 LIMITE_TURNO=20, no input after reset -> timeout high in one cycle, turno toggles, colocar stays 0.
REQ-034 Reset asserted during PAUSA with j1_dir held -> outputs 0 immediately; no pulse after release until the button is released and pressed again.
REQ-035 With AUTO_REPETIR_EN defined, PAUSA_CICLOS=4, j1_dir=0001 held 20 cycles -> izquierda pulses every 5 cycles; without the macro -> one pulse only.

Source files
------------

// File: rtl/arbitro_cursor.sv
// Turn arbiter: turns two players' button levels into cursor move, place and timeout pulses.
// Optional AUTO_REPETIR_EN: a direction still held at the end of PAUSA moves again.
module arbitro_cursor #(
  parameter int unsigned PAUSA_CICLOS = 4,
  parameter int unsigned LIMITE_TURNO = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] j1_dir,
  input  logic       j1_ok,
  input  logic [3:0] j2_dir,
  input  logic       j2_ok,
  output logic       arriba,
  output logic       abajo,
  output logic       derecha,
  output logic       izquierda,
  output logic       colocar,
  output logic       timeout,
  output logic       turno,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    MOVER  = 2'd1,
    PAUSA  = 2'd2,
    CAMBIO = 2'd3
  } estado_t;

  localparam logic [7:0]  PAUSA_FIN = 8'(PAUSA_CICLOS - 1);
  localparam logic [15:0] TURNO_FIN = 16'(LIMITE_TURNO - 1);

  estado_t     st_q, st_d;
  logic [4:0]  prev1_q, prev2_q;
  logic [3:0]  dir_q, dir_d;
  logic [7:0]  pausa_q, pausa_d;
  logic [15:0] timer_q, timer_d;
  logic        por_ok_q, por_ok_d;
  logic        turno_q, turno_d;

  logic [4:0]  act_cur;
  logic [4:0]  act_prev;
  logic [4:0]  sube;
  logic [3:0]  dir_sel;
  logic        expira;
  logic        fin_pausa;

  // Both players are tracked every cycle so a held button never rises at turn change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev1_q <= '1;
      prev2_q <= '1;
    end else begin
      prev1_q <= {j1_dir, j1_ok};
      prev2_q <= {j2_dir, j2_ok};
    end
  end

  assign act_cur  = turno_q ? {j2_dir, j2_ok} : {j1_dir, j1_ok};
  assign act_prev = turno_q ? prev2_q : prev1_q;
  assign sube     = act_cur & ~act_prev;

  assign expira    = (timer_q == TURNO_FIN);
  assign fin_pausa = (pausa_q == PAUSA_FIN);

  always_comb begin
    dir_sel = 4'b0000;
    priority case (1'b1)
      sube[4]: dir_sel = 4'b1000;
      sube[3]: dir_sel = 4'b0100;
      sube[2]: dir_sel = 4'b0010;
      sube[1]: dir_sel = 4'b0001;
      default: dir_sel = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= ESPERA;
      dir_q    <= 4'b0000;
      pausa_q  <= 8'd0;
      timer_q  <= 16'd0;
      por_ok_q <= 1'b0;
      turno_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      dir_q    <= dir_d;
      pausa_q  <= pausa_d;
      timer_q  <= timer_d;
      por_ok_q <= por_ok_d;
      turno_q  <= turno_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    dir_d    = dir_q;
    pausa_d  = pausa_q;
    timer_d  = timer_q;
    por_ok_d = por_ok_q;
    turno_d  = turno_q;
    unique case (st_q)
      ESPERA: begin
        timer_d = timer_q + 16'd1;
        if (sube[0]) begin
          st_d     = CAMBIO;
          por_ok_d = 1'b1;
        end else if (expira) begin
          st_d     = CAMBIO;
          por_ok_d = 1'b0;
        end else if (|sube[4:1]) begin
          st_d  = MOVER;
          dir_d = dir_sel;
        end
      end
      MOVER: begin
        timer_d = 16'd0;
        pausa_d = 8'd0;
        st_d    = PAUSA;
      end
      PAUSA: begin
        timer_d = timer_q + 16'd1;
        pausa_d = pausa_q + 8'd1;
        if (expira) begin
          st_d     = CAMBIO;
          por_ok_d = 1'b0;
        end else if (fin_pausa) begin
`ifdef AUTO_REPETIR_EN
          if (|(dir_q & act_cur[4:1])) begin
            st_d = MOVER;
          end else begin
            st_d = ESPERA;
          end
`else
          st_d = ESPERA;
`endif
        end
      end
      CAMBIO: begin
        timer_d = 16'd0;
        turno_d = ~turno_q;
        st_d    = ESPERA;
      end
      default: st_d = ESPERA;
    endcase
  end

  assign arriba    = (st_q == MOVER) & dir_q[3];
  assign abajo     = (st_q == MOVER) & dir_q[2];
  assign derecha   = (st_q == MOVER) & dir_q[1];
  assign izquierda = (st_q == MOVER) & dir_q[0];
  assign colocar   = (st_q == CAMBIO) & por_ok_q;
  assign timeout   = (st_q == CAMBIO) & ~por_ok_q;
  assign turno     = turno_q;
  assign estado    = st_q;

endmodule

// File: tb/tb_arbitro_cursor.sv
// Bench for arbitro_cursor: directed scenarios plus random levels
// checked every cycle against a turn/phase reference model.
module tb_arbitro_cursor;

  localparam int PAU = 4;
  localparam int LIM = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] j1_dir = 4'b0000;
  logic [3:0] j2_dir = 4'b0000;
  logic       j1_ok = 1'b0;
  logic       j2_ok = 1'b0;
  logic       arriba, abajo, derecha, izquierda;
  logic       colocar, timeout, turno;
  logic [1:0] estado;
  logic [8:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arbitro_cursor #(
    .PAUSA_CICLOS(PAU),
    .LIMITE_TURNO(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .j1_dir(j1_dir),
    .j1_ok(j1_ok),
    .j2_dir(j2_dir),
    .j2_ok(j2_ok),
    .arriba(arriba),
    .abajo(abajo),
    .derecha(derecha),
    .izquierda(izquierda),
    .colocar(colocar),
    .timeout(timeout),
    .turno(turno),
    .estado(estado)
  );

  assign obs = {estado, turno, arriba, abajo, derecha,
                izquierda, colocar, timeout};

  // Reference model: phase 0 idle, 1 move, 2 pause, 3 turn change.
  int         m_fase;
  int         m_jug;
  int         m_idle;
  int         m_resto;
  int         m_dir;
  int         m_porok;
  logic [4:0] m_prev [2];

  task automatic model_reset();
    m_fase   = 0;
    m_jug    = 0;
    m_idle   = 0;
    m_resto  = 0;
    m_dir    = 0;
    m_porok  = 0;
    m_prev[0] = 5'b11111;
    m_prev[1] = 5'b11111;
  endtask

  task automatic model_step();
    logic [4:0] cur;
    logic [4:0] rise;
    bit         vence;
    cur  = (m_jug == 1) ? {j2_dir, j2_ok} : {j1_dir, j1_ok};
    rise = cur & ~m_prev[m_jug];
    vence = (m_idle == LIM - 1);
    m_prev[0] = {j1_dir, j1_ok};
    m_prev[1] = {j2_dir, j2_ok};
    case (m_fase)
      0: begin
        m_idle++;
        if (rise[0]) begin
          m_fase = 3;
          m_porok = 1;
        end else if (vence) begin
          m_fase = 3;
          m_porok = 0;
        end else if (rise[4:1] != 4'b0000) begin
          m_fase = 1;
          if (rise[4]) m_dir = 3;
          else if (rise[3]) m_dir = 2;
          else if (rise[2]) m_dir = 1;
          else m_dir = 0;
        end
      end
      1: begin
        m_idle = 0;
        m_resto = PAU;
        m_fase = 2;
      end
      2: begin
        m_idle++;
        m_resto--;
        if (vence) begin
          m_fase = 3;
          m_porok = 0;
        end else if (m_resto == 0) begin
          m_fase = 0;
`ifdef AUTO_REPETIR_EN
          if (cur[m_dir + 1]) m_fase = 1;
`endif
        end
      end
      default: begin
        m_idle = 0;
        m_jug = 1 - m_jug;
        m_fase = 0;
      end
    endcase
  endtask

  function automatic logic [8:0] model_out();
    logic [3:0] mv;
    logic       col;
    logic       tmo;
    mv = 4'b0000;
    if (m_fase == 1) mv[m_dir] = 1'b1;
    col = (m_fase == 3) && (m_porok == 1);
    tmo = (m_fase == 3) && (m_porok == 0);
    return {2'(m_fase), (m_jug == 1), mv, col, tmo};
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    {j1_dir, j1_ok, j2_dir, j2_ok} = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 9'd0) begin
      failures++;
      $display("FAIL reset_init got=%b exp=%b", obs, 9'd0);
    end
    do_reset();
    checks++;
    if (obs !== model_out()) begin
      failures++;
      $display("FAIL reset_after got=%b exp=%b", obs, model_out());
    end
  endtask

  task automatic test_single_move();
    int seq [6];
    int n;
    seq = '{1, 2, 2, 2, 2, 0};
    n = 0;
    do_reset();
    j1_dir = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (arriba) n++;
      if (i < 6) begin
        checks++;
        if (estado !== 2'(seq[i])) begin
          failures++;
          $display("FAIL move_estado cyc=%0d got=%0d exp=%0d", i, estado, seq[i]);
        end
      end
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("FAIL move_model cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL move_count got=%0d exp=1", n);
    end
  endtask

  task automatic test_priority();
    int n_ab;
    int n_de;
    n_ab = 0;
    n_de = 0;
    do_reset();
    j1_dir = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (abajo) n_ab++;
      if (derecha) n_de++;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("FAIL prio_model cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
    end
    checks++;
    if (n_ab != 1 || n_de != 0) begin
      failures++;
      $display("FAIL prio_count got=abajo%0d/derecha%0d exp=1/0", n_ab, n_de);
    end
  endtask

  task automatic test_turn_change();
    do_reset();
    j2_dir = 4'b1111;
    j2_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs !== 9'd0) begin
        failures++;
        $display("FAIL inactive cyc=%0d got=%b exp=%b", i, obs, 9'd0);
      end
    end
    j1_ok = 1'b1;
    cycle();
    checks++;
    if (colocar !== 1'b1 || timeout !== 1'b0 || turno !== 1'b0) begin
      failures++;
      $display("FAIL colocar got=%b%b%b exp=100", colocar, timeout, turno);
    end
    cycle();
    checks++;
    if (turno !== 1'b1 || estado !== 2'd0) begin
      failures++;
      $display("FAIL turno_new got=%b/%0d exp=1/0", turno, estado);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (obs !== 9'b001000000) begin
        failures++;
        $display("FAIL held_new cyc=%0d got=%b exp=%b", i, obs, 9'b001000000);
      end
    end
  endtask

  task automatic test_timeout();
    int n_t;
    int n_c;
    n_t = 0;
    n_c = 0;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (timeout) n_t++;
      if (colocar) n_c++;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("FAIL tmo_model cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
    end
    checks++;
    if (n_t != 1 || n_c != 0 || turno !== 1'b1) begin
      failures++;
      $display("FAIL tmo_count got=t%0d c%0d turno%b exp=t1 c0 turno1", n_t, n_c, turno);
    end
  endtask

  task automatic test_ok_vs_expiry();
    bit hit;
    hit = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (m_fase == 0 && m_idle == LIM - 1) begin
        hit = 1;
        break;
      end
      cycle();
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL okexp_wait got=timeout exp=expiry_cycle");
    end
    j1_ok = 1'b1;
    cycle();
    checks++;
    if (colocar !== 1'b1 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL okexp got=c%b t%b exp=c1 t0", colocar, timeout);
    end
  endtask

  task automatic test_reset_mid_pausa();
    int n;
    n = 0;
    do_reset();
    j1_dir = 4'b1000;
    repeat (3) cycle();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 9'd0) begin
      failures++;
      $display("FAIL rst_pausa got=%b exp=%b", obs, 9'd0);
    end
    repeat (2) cycle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs[5:0] != 6'd0) n++;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("FAIL rst_hold cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL rst_held_pulses got=%0d exp=0", n);
    end
    j1_dir = 4'b0000;
    cycle();
    j1_dir = 4'b1000;
    cycle();
    checks++;
    if (arriba !== 1'b1) begin
      failures++;
      $display("FAIL rst_repress got=%b exp=1", arriba);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int exp_n;
    n = 0;
`ifdef AUTO_REPETIR_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    do_reset();
    j1_dir = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (izquierda) n++;
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("FAIL rep_model cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
    end
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL rep_count got=%0d exp=%0d", n, exp_n);
    end
  endtask

  task automatic test_random();
    logic [9:0] v;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      v = {j1_dir, j1_ok, j2_dir, j2_ok};
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 7) == 0) v[k] = ~v[k];
      end
      {j1_dir, j1_ok, j2_dir, j2_ok} = v;
      cycle();
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("FAIL rnd_model cyc=%0d got=%b exp=%b", i, obs, model_out());
      end
      checks++;
      if ($countones(obs[5:0]) > 1) begin
        failures++;
        $display("FAIL rnd_onehot cyc=%0d got=%b exp=at_most_one", i, obs[5:0]);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_move();
    test_priority();
    test_turn_change();
    test_timeout();
    test_ok_vs_expiry();
    test_reset_mid_pausa();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
